// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider family: monitor FSM encoding and
// default counter sizing, also used by the divider and its benches.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_e;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control and status bundle between a divided-clock monitor and its host
// (status registers plus the divided clock under test).
interface clk_div_monitor_if #(
  parameter int unsigned CNT_W = clk_div_pkg::CNT_W_DEF
);
  logic             div_clk;
  logic             chk_en;
  logic [CNT_W-1:0] exp_ratio;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             ratio_err;
  logic             timeout;

  modport master (
    output div_clk, chk_en, exp_ratio,
    input  period, high_time, meas_valid, locked, ratio_err, timeout
  );

  modport slave (
    input  div_clk, chk_en, exp_ratio,
    output period, high_time, meas_valid, locked, ratio_err, timeout
  );
endinterface

// File: rtl/clk_edge_det.sv
// Two-flop sampler for a clk-synchronous signal; rise/fall are decoded from
// the flops so they are glitch-free and one clk cycle wide.
module clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic d1_q, d2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= sig_i;
      d2_q <= d1_q;
    end
  end

  assign level_o = d1_q;
  assign rise_o  = d1_q & ~d2_q;
  assign fall_o  = ~d1_q & d2_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period and high time of div_clk in clk
// cycles, compares the period to exp_ratio and reports lock, error and loss of clock.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_monitor_if.slave mon
);
  // state | meaning
  // IDLE  | monitor off; lock, match count, timeout and run counter cleared
  // ARM   | waiting for a rising edge to open the first period
  // MEAS  | every rise publishes the period that just closed

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_M1 = 4'(LOCK_CNT - 1);

  mon_state_e       state_q, state_d;
  logic             rise, fall, lvl;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] hi_run_q, hi_lat_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic [3:0]       match_cnt_q;
  logic             meas_valid_q, locked_q, ratio_err_q, timeout_q;
  logic             run_sat, match, publish, tmo_hit;

  clk_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (mon.div_clk),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign run_sat = (run_cnt_q == CNT_MAX);
  assign match   = (run_cnt_q == mon.exp_ratio);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // A saturated run counter is never published; it raises timeout instead.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    tmo_hit = 1'b0;
    if (!mon.chk_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          tmo_hit = run_sat;
          if (rise) state_d = ST_MEAS;
        end
        ST_MEAS: begin
          if (run_sat) begin
            tmo_hit = 1'b1;
            if (!rise) state_d = ST_ARM;
          end else begin
            publish = rise;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!mon.chk_en || state_q == ST_IDLE) run_cnt_d = '0;
    else if (rise)                         run_cnt_d = CNT_ONE;
    else if (!run_sat)                     run_cnt_d = run_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_cnt_q <= '0;
    else      run_cnt_q <= run_cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_run_q <= '0;
      hi_lat_q <= '0;
    end else begin
      if (rise)                         hi_run_q <= CNT_ONE;
      else if (lvl && hi_run_q != CNT_MAX) hi_run_q <= hi_run_q + CNT_ONE;
      if (fall) hi_lat_q <= hi_run_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      ratio_err_q  <= 1'b0;
    end else begin
      meas_valid_q <= publish;
      ratio_err_q  <= publish & ~match;
      if (publish) begin
        period_q    <= run_cnt_q;
        high_time_q <= hi_lat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (!mon.chk_en) begin
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (tmo_hit) begin
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b1;
    end else if (publish) begin
      if (match) begin
        if (match_cnt_q <= LOCK_M1) match_cnt_q <= match_cnt_q + 4'd1;
        locked_q <= (match_cnt_q >= LOCK_M1);
      end else begin
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
      end
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.locked     = locked_q;
  assign mon.ratio_err  = ratio_err_q;
  assign mon.timeout    = timeout_q;
endmodule
